// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester winner selection. Round-robin on ties by default;
// fixed priority (requester 0) when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
`ifdef RAM_ARB_FIXED_PRIO_EN
    if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
`else
    // On a tie the requester that did not win last time goes first.
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
`endif
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM; all outputs registered.
// Optional macro RAM_ARB_FIXED_PRIO_EN replaces round-robin with fixed priority.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            state_reg, state_next;
  logic              win_reg, win_next;
  logic [1:0]        gnt_reg, gnt_next;
  logic [1:0]        rvalid_reg, rvalid_next;
  logic [DATA_W-1:0] rdata_reg [2];
  logic              ram_en_reg, ram_en_next;
  logic              ram_we_reg, ram_we_next;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
  logic [1:0]        arb_gnt;
  logic              arb_last;
  logic              win_idx;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign arb_last = 1'b0;
`else
  logic last_reg;
  assign arb_last = last_reg;

  // Reset value 1 makes requester 0 the winner of the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= 1'b1;
    end else if (state_reg == IDLE && (req0 || req1)) begin
      last_reg <= win_idx;
    end
  end
`endif

  rr_arb2 u_arb (
    .req  ({req1, req0}),
    .last (arb_last),
    .gnt  (arb_gnt)
  );

  assign win_idx = arb_gnt[1];

  always_comb begin
    state_next     = state_reg;
    win_next       = win_reg;
    gnt_next       = 2'b00;
    rvalid_next    = 2'b00;
    ram_en_next    = 1'b0;
    ram_we_next    = 1'b0;
    ram_addr_next  = ram_addr_reg;
    ram_wdata_next = ram_wdata_reg;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          state_next     = ACCESS;
          win_next       = win_idx;
          gnt_next       = arb_gnt;
          ram_en_next    = 1'b1;
          ram_we_next    = win_idx ? we1 : we0;
          ram_addr_next  = win_idx ? addr1 : addr0;
          ram_wdata_next = win_idx ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        state_next = ram_we_reg ? IDLE : RESP;
      end
      RESP: begin
        state_next           = IDLE;
        rvalid_next[win_reg] = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      win_reg       <= 1'b0;
      gnt_reg       <= 2'b00;
      rvalid_reg    <= 2'b00;
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      win_reg       <= win_next;
      gnt_reg       <= gnt_next;
      rvalid_reg    <= rvalid_next;
      ram_en_reg    <= ram_en_next;
      ram_we_reg    <= ram_we_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wdata_reg <= ram_wdata_next;
    end
  end

  // Each port's read data only moves on its own read completion.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_reg[gi] <= '0;
      end else if (state_reg == RESP && win_reg == 1'(gi)) begin
        rdata_reg[gi] <= ram_rdata;
      end
    end
  end

  assign gnt0      = gnt_reg[0];
  assign gnt1      = gnt_reg[1];
  assign rvalid0   = rvalid_reg[0];
  assign rvalid1   = rvalid_reg[1];
  assign rdata0    = rdata_reg[0];
  assign rdata1    = rdata_reg[1];
  assign ram_en    = ram_en_reg;
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural synchronous RAM.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [2:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_en, ram_we;
  logic [2:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic [7:0] mem [8];

  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic drive(input int port, input logic r, input logic w,
                       input logic [2:0] a, input logic [7:0] d);
    if (port == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // Issues one access; latencies are -1 when the event never arrived.
  task automatic do_access(input int port, input logic w, input logic [2:0] a,
                           input logic [7:0] d, output int gnt_lat,
                           output int rv_lat, output logic [7:0] rd);
    logic g, v;
    gnt_lat = -1;
    rv_lat  = -1;
    rd      = '0;
    @(negedge clk);
    drive(port, 1'b1, w, a, d);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      g = (port == 0) ? gnt0 : gnt1;
      if (g) begin gnt_lat = i; break; end
    end
    drive(port, 1'b0, w, a, d);
    if (gnt_lat > 0 && !w) begin
      for (int i = 1; i <= 6; i++) begin
        @(posedge clk); #1;
        v = (port == 0) ? rvalid0 : rvalid1;
        if (v) begin
          rv_lat = i;
          rd = (port == 0) ? rdata0 : rdata1;
          break;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000", {gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we});
    end
    checks++;
    if ({rdata0, rdata1, ram_addr, ram_wdata} !== 27'd0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {rdata0, rdata1, ram_addr, ram_wdata});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    int gl, rl;
    logic [7:0] rd;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 3'd3, 8'hA5);
    @(posedge clk); #1;
    checks++;
    if ({gnt0, gnt1, ram_en, ram_we, ram_addr, ram_wdata} !== {4'b1011, 3'd3, 8'hA5}) begin
      errors++;
      $display("FAIL wr_access got %b %b %b %b %h %h want 1 0 1 1 3 a5",
               gnt0, gnt1, ram_en, ram_we, ram_addr, ram_wdata);
    end
    drive(0, 1'b0, 1'b0, 3'd0, 8'h00);
    @(posedge clk); #1;
    checks++;
    if ({gnt0, ram_en, ram_we} !== 3'b000) begin
      errors++;
      $display("FAIL wr_after got %b want 000", {gnt0, ram_en, ram_we});
    end
    do_access(0, 1'b0, 3'd3, 8'h00, gl, rl, rd);
    checks++;
    if (gl !== 1) begin errors++; $display("FAIL rd_gnt_lat got %0d want 1", gl); end
    checks++;
    if (rl !== 2) begin errors++; $display("FAIL rd_rvalid_lat got %0d want 2", rl); end
    checks++;
    if (rd !== 8'hA5) begin errors++; $display("FAIL rd_data got %h want a5", rd); end
    @(posedge clk); #1;
    checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== 8'hA5) begin
      errors++;
      $display("FAIL rd_hold got rvalid0=%b rdata0=%h want 0 a5", rvalid0, rdata0);
    end
  endtask

  task automatic test_tie;
    int gl;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 3'd1, 8'h00);
    drive(1, 1'b1, 1'b1, 3'd2, 8'h3C);
    @(posedge clk); #1;
    checks++;
    if ({gnt1, gnt0} !== 2'b01) begin
      errors++;
      $display("FAIL tie1 got gnt1,gnt0=%b want 01", {gnt1, gnt0});
    end
    drive(0, 1'b0, 1'b0, 3'd1, 8'h00);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 3'd2, 8'h00);
    @(posedge clk); #1;
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== mem[1]) begin
      errors++;
      $display("FAIL tie1_read got rvalid0=%b rdata0=%h want 1 %h", rvalid0, rdata0, mem[1]);
    end
    @(posedge clk); #1;
    checks++;
    if ({gnt1, gnt0} !== 2'b10) begin
      errors++;
      $display("FAIL tie2 got gnt1,gnt0=%b want 10", {gnt1, gnt0});
    end
    drive(1, 1'b0, 1'b0, 3'd0, 8'h00);
    gl = -1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (gnt0) begin gl = i; break; end
    end
    drive(0, 1'b0, 1'b0, 3'd0, 8'h00);
    checks++;
    if (gl !== 2) begin errors++; $display("FAIL tie2_second got lat %0d want 2", gl); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h3C) begin
      errors++;
      $display("FAIL tie_written got rvalid0=%b rdata0=%h want 1 3c", rvalid0, rdata0);
    end
  endtask

  task automatic test_contention;
    int who;
    logic exp_who;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 3'd4, 8'h40);
    drive(1, 1'b1, 1'b1, 3'd6, 8'h60);
    for (int k = 0; k < 8; k++) begin
      who = -1;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (gnt0 || gnt1) begin who = {gnt1, gnt0}; break; end
      end
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp_who = 1'b0;
`else
      exp_who = k[0];
`endif
      checks++;
      if (who !== (exp_who ? 2 : 1)) begin
        errors++;
        $display("FAIL contention_%0d got gnt1,gnt0=%0d want %0d", k, who, exp_who ? 2 : 1);
      end
    end
    drive(0, 1'b0, 1'b0, 3'd0, 8'h00);
    drive(1, 1'b0, 1'b0, 3'd0, 8'h00);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_wrap;
    int gl, rl;
    logic [7:0] rd;
    do_access(1, 1'b1, 3'd7, 8'hFF, gl, rl, rd);
    checks++;
    if (gl < 1) begin errors++; $display("FAIL wrap_wr7 got no gnt1 want gnt1"); end
    do_access(0, 1'b1, 3'd0, 8'h01, gl, rl, rd);
    checks++;
    if (gl < 1) begin errors++; $display("FAIL wrap_wr0 got no gnt0 want gnt0"); end
    do_access(1, 1'b0, 3'd7, 8'h00, gl, rl, rd);
    checks++;
    if (rd !== 8'hFF || rdata1 !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_rd7 got %h want ff", rd);
    end
    do_access(0, 1'b0, 3'd0, 8'h00, gl, rl, rd);
    checks++;
    if (rd !== 8'h01 || rdata1 !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_rd0 got rdata0=%h rdata1=%h want 01 ff", rd, rdata1);
    end
  endtask

  task automatic test_reset_mid_read;
    int gl, rl;
    logic [7:0] rd;
    logic seen;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 3'd7, 8'h00);
    @(posedge clk); #1;
    checks++;
    if (gnt0 !== 1'b1) begin errors++; $display("FAIL abort_gnt got %b want 1", gnt0); end
    drive(0, 1'b0, 1'b0, 3'd0, 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we, rdata0, rdata1, ram_addr, ram_wdata} !== 33'd0) begin
      errors++;
      $display("FAIL abort_outputs got %h want 0",
               {gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we, rdata0, rdata1, ram_addr, ram_wdata});
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rvalid0 || rvalid1 || gnt0 || gnt1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_quiet got activity=%b want 0", seen); end
    do_access(1, 1'b0, 3'd0, 8'h00, gl, rl, rd);
    checks++;
    if (gl !== 1 || rd !== 8'h01) begin
      errors++;
      $display("FAIL abort_recover got lat=%0d data=%h want 1 01", gl, rd);
    end
  endtask

  task automatic test_isolation;
    int gl, rl;
    logic [7:0] rd;
    logic bad;
    do_access(0, 1'b1, 3'd5, 8'h5A, gl, rl, rd);
    do_access(0, 1'b0, 3'd5, 8'h00, gl, rl, rd);
    checks++;
    if (rd !== 8'h5A) begin errors++; $display("FAIL iso_setup got %h want 5a", rd); end
    bad = 1'b0;
    rd  = 8'h00;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 3'd7, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rdata0 !== 8'h5A || rvalid0 !== 1'b0 || gnt0 !== 1'b0) bad = 1'b1;
      if (gnt1) drive(1, 1'b0, 1'b0, 3'd0, 8'h00);
      if (rvalid1) rd = rdata1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL iso_port0 got disturbed rdata0=%h want 5a unchanged", rdata0);
    end
    checks++;
    if (rd !== 8'hFF) begin errors++; $display("FAIL iso_port1 got %h want ff", rd); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    test_reset();
    test_write_read();
    test_tie();
    test_contention();
    test_wrap();
    test_reset_mid_read();
    test_isolation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
